// File: rtl/mem_pkg.sv
// Shared types and the default peripheral address map for the data-side MMIO interconnect.
package mem_pkg;

    typedef enum logic [1:0] {SLV_RAM, SLV_ROM, SLV_GPIO, SLV_UART} slv_idx_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mmio_state_t;

    // Element [i] belongs to channel slv_idx_t'(i); the concatenation lists the highest index first.
    localparam logic [3:0][31:0] SLV_BASE_DEF = {
        32'h1001_0300,  // UART
        32'h1001_0200,  // GPIO
        32'h0040_0000,  // ROM
        32'h1001_0000   // RAM
    };

    localparam logic [3:0][31:0] SLV_MASK_DEF = {
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFC0_0000,
        32'hFFFF_FE00
    };

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational base/mask address decode: any-hit flag, lowest-index winner and in-window offset.
module mmio_addr_decoder #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int SEL_W   = 2,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [ADDR_W-1:0] offset_o
);

    logic [NUM_SLV-1:0] hit_vec;

    always_comb begin
        hit_vec = '0;
        sel_o   = '0;
        for (int i = 0; i < NUM_SLV; i++)
            hit_vec[i] = ((addr_i ^ SLV_BASE[i]) & SLV_MASK[i]) == '0;
        // Scan from the top so the lowest matching channel overrides any higher one.
        for (int i = NUM_SLV - 1; i >= 0; i--)
            if (hit_vec[i]) sel_o = SEL_W'(i);
        hit_o    = |hit_vec;
        offset_o = addr_i & ~SLV_MASK[sel_o];
    end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-outstanding MMIO interconnect: decodes the core data port onto NUM_SLV slave channels,
// waits for the selected slave (with optional timeout) and returns one registered response.
module mmio_interconnect
    import mem_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = mem_pkg::SLV_BASE_DEF,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = mem_pkg::SLV_MASK_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_req_i,
    input  logic                      m_we_i,
    input  logic [ADDR_W-1:0]         m_addr_i,
    input  logic [DATA_W-1:0]         m_wdata_i,
    input  logic [DATA_W/8-1:0]       m_be_i,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      m_ready_o,
    output logic                      m_err_o,
    output logic [NUM_SLV-1:0]        s_req_o,
    output logic                      s_we_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [DATA_W/8-1:0]       s_be_o,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_SLV-1:0]        s_ready_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    mmio_state_t        state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_SLV-1:0] s_req_q;
    logic               s_we_q;
    logic [ADDR_W-1:0]  s_addr_q;
    logic [DATA_W-1:0]  s_wdata_q;
    logic [BE_W-1:0]    s_be_q;
    logic [DATA_W-1:0]  m_rdata_q;
    logic               m_ready_q;
    logic               m_err_q;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic [ADDR_W-1:0]  dec_off;

    mmio_addr_decoder #(
        .NUM_SLV (NUM_SLV),
        .ADDR_W  (ADDR_W),
        .SEL_W   (SEL_W),
        .SLV_BASE(SLV_BASE),
        .SLV_MASK(SLV_MASK)
    ) u_dec (
        .addr_i  (m_addr_i),
        .hit_o   (dec_hit),
        .sel_o   (dec_sel),
        .offset_o(dec_off)
    );

    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;

    assign sel_ready   = s_ready_i[sel_q];
    assign sel_rdata   = s_rdata_i[32'(sel_q) * DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_req_i) begin
                        if (dec_hit) begin
                            sel_q     <= dec_sel;
                            s_req_q   <= NUM_SLV'(1) << dec_sel;
                            s_we_q    <= m_we_i;
                            s_addr_q  <= dec_off;
                            s_wdata_q <= m_wdata_i;
                            s_be_q    <= m_be_i;
                            cnt_q     <= '0;
                            state_q   <= WAIT;
                        end else begin
                            m_err_q   <= 1'b1;
                            m_rdata_q <= '0;
                            m_ready_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Ready is checked first so a response on the expiry cycle is not an error.
                    if (sel_ready) begin
                        s_req_q   <= '0;
                        m_rdata_q <= s_we_q ? '0 : sel_rdata;
                        m_err_q   <= 1'b0;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (timeout_hit) begin
                        s_req_q   <= '0;
                        m_rdata_q <= '0;
                        m_err_q   <= 1'b1;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    m_ready_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_rdata_o = m_rdata_q;
    assign m_ready_o = m_ready_q;
    assign m_err_o   = m_err_q;
    assign s_req_o   = s_req_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign s_be_o    = s_be_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect on the default four-channel map (RAM/ROM/GPIO/UART).
module tb_mmio_interconnect;

    logic         clk;
    logic         rst_n;
    logic         m_req_i;
    logic         m_we_i;
    logic [31:0]  m_addr_i;
    logic [31:0]  m_wdata_i;
    logic [3:0]   m_be_i;
    logic [31:0]  m_rdata_o;
    logic         m_ready_o;
    logic         m_err_o;
    logic [3:0]   s_req_o;
    logic         s_we_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [3:0]   s_be_o;
    logic [127:0] s_rdata_i;
    logic [3:0]   s_ready_i;

    int n_chk;
    int n_fail;

    mmio_interconnect #(
        .NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req_i  (m_req_i),
        .m_we_i   (m_we_i),
        .m_addr_i (m_addr_i),
        .m_wdata_i(m_wdata_i),
        .m_be_i   (m_be_i),
        .m_rdata_o(m_rdata_o),
        .m_ready_o(m_ready_o),
        .m_err_o  (m_err_o),
        .s_req_o  (s_req_o),
        .s_we_o   (s_we_o),
        .s_addr_o (s_addr_o),
        .s_wdata_o(s_wdata_o),
        .s_be_o   (s_be_o),
        .s_rdata_i(s_rdata_i),
        .s_ready_i(s_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0;
        m_wdata_i = '0; m_be_i = '0; s_rdata_i = '0; s_ready_i = '0;
        tick(); tick();
        n_chk += 8;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b exp 0", m_ready_o); end
        if (m_err_o   !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b exp 0", m_err_o); end
        if (m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", m_rdata_o); end
        if (s_req_o   !== 4'h0) begin n_fail++; $display("FAIL rst_sreq got %b exp 0000", s_req_o); end
        if (s_we_o    !== 1'b0) begin n_fail++; $display("FAIL rst_swe got %0b exp 0", s_we_o); end
        if (s_addr_o  !== 32'h0) begin n_fail++; $display("FAIL rst_saddr got %h exp 0", s_addr_o); end
        if (s_wdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_swdata got %h exp 0", s_wdata_o); end
        if (s_be_o    !== 4'h0) begin n_fail++; $display("FAIL rst_sbe got %b exp 0000", s_be_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_gpio_read();
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1001_0204; m_be_i = 4'hF;
        tick();
        n_chk += 3;
        if (s_req_o !== 4'b0100) begin n_fail++; $display("FAIL gpio_sreq got %b exp 0100", s_req_o); end
        if (s_addr_o !== 32'h0000_0004) begin n_fail++; $display("FAIL gpio_saddr got %h exp 00000004", s_addr_o); end
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL gpio_early_ready got %0b exp 0", m_ready_o); end
        s_ready_i = 4'b0100;
        s_rdata_i[64 +: 32] = 32'h0000_00A5;
        tick();
        n_chk += 4;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL gpio_ready got %0b exp 1", m_ready_o); end
        if (m_rdata_o !== 32'h0000_00A5) begin n_fail++; $display("FAIL gpio_rdata got %h exp 000000a5", m_rdata_o); end
        if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL gpio_err got %0b exp 0", m_err_o); end
        if (s_req_o !== 4'b0000) begin n_fail++; $display("FAIL gpio_sreq_drop got %b exp 0000", s_req_o); end
        m_req_i = 1'b0; s_ready_i = '0;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL gpio_pulse got %0b exp 0", m_ready_o); end
        if (m_rdata_o !== 32'h0000_00A5) begin n_fail++; $display("FAIL gpio_hold got %h exp 000000a5", m_rdata_o); end
    endtask

    task automatic test_timeout();
        // Never-ready RAM read; a stray ready on the unselected ROM channel must be ignored.
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1001_0010;
        s_ready_i = 4'b0010;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_chk += 2;
            if (s_req_o !== 4'b0001) begin n_fail++; $display("FAIL to_sreq cyc %0d got %b exp 0001", i, s_req_o); end
            if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL to_early_ready cyc %0d got %0b exp 0", i, m_ready_o); end
            tick();
        end
        n_chk += 4;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL to_ready got %0b exp 1", m_ready_o); end
        if (m_err_o !== 1'b1) begin n_fail++; $display("FAIL to_err got %0b exp 1", m_err_o); end
        if (m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h exp 0", m_rdata_o); end
        if (s_req_o !== 4'b0000) begin n_fail++; $display("FAIL to_sreq_drop got %b exp 0000", s_req_o); end
        m_req_i = 1'b0; s_ready_i = '0;
        tick();

        // Same read, but the slave answers on the 16th WAIT cycle: ready beats the timeout.
        m_req_i = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_chk += 1;
        if (s_req_o !== 4'b0001) begin n_fail++; $display("FAIL edge_sreq got %b exp 0001", s_req_o); end
        s_ready_i = 4'b0001;
        s_rdata_i[0 +: 32] = 32'hDEAD_BEEF;
        tick();
        n_chk += 3;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL edge_ready got %0b exp 1", m_ready_o); end
        if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL edge_err got %0b exp 0", m_err_o); end
        if (m_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL edge_rdata got %h exp deadbeef", m_rdata_o); end
        m_req_i = 1'b0; s_ready_i = '0;
        tick();
    endtask

    task automatic test_uart_write();
        m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h1001_0300;
        m_wdata_i = 32'h0000_0041; m_be_i = 4'b0001;
        s_rdata_i[96 +: 32] = 32'hFFFF_FFFF;
        tick();
        n_chk += 4;
        if (s_we_o !== 1'b1) begin n_fail++; $display("FAIL uart_swe got %0b exp 1", s_we_o); end
        if (s_wdata_o !== 32'h0000_0041) begin n_fail++; $display("FAIL uart_swdata got %h exp 00000041", s_wdata_o); end
        if (s_be_o !== 4'b0001) begin n_fail++; $display("FAIL uart_sbe got %b exp 0001", s_be_o); end
        if (s_addr_o !== 32'h0) begin n_fail++; $display("FAIL uart_saddr got %h exp 0", s_addr_o); end
        for (int i = 0; i < 3; i++) begin
            n_chk += 2;
            if (s_req_o !== 4'b1000) begin n_fail++; $display("FAIL uart_sreq cyc %0d got %b exp 1000", i, s_req_o); end
            if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL uart_early_ready cyc %0d got %0b exp 0", i, m_ready_o); end
            if (i == 2) s_ready_i = 4'b1000;
            tick();
        end
        n_chk += 3;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL uart_ready got %0b exp 1", m_ready_o); end
        if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL uart_err got %0b exp 0", m_err_o); end
        if (m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL uart_rdata got %h exp 0", m_rdata_o); end
        m_req_i = 1'b0; m_we_i = 1'b0; s_ready_i = '0;
        tick();
        n_chk += 1;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL uart_pulse got %0b exp 0", m_ready_o); end
    endtask

    task automatic test_miss();
        // Park a nonzero value in m_rdata_o first so the miss visibly clears it.
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1001_0204;
        tick();
        s_ready_i = 4'b0100;
        tick();
        m_req_i = 1'b0; s_ready_i = '0;
        tick();
        m_req_i = 1'b1; m_addr_i = 32'h2000_0000;
        tick();
        n_chk += 4;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL miss_ready got %0b exp 1", m_ready_o); end
        if (m_err_o !== 1'b1) begin n_fail++; $display("FAIL miss_err got %0b exp 1", m_err_o); end
        if (m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL miss_rdata got %h exp 0", m_rdata_o); end
        if (s_req_o !== 4'b0000) begin n_fail++; $display("FAIL miss_sreq got %b exp 0000", s_req_o); end
        m_req_i = 1'b0;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL miss_pulse got %0b exp 0", m_ready_o); end
        if (m_err_o !== 1'b1) begin n_fail++; $display("FAIL miss_err_hold got %0b exp 1", m_err_o); end
    endtask

    task automatic test_reset_mid();
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1001_0020;
        tick();
        n_chk += 1;
        if (s_req_o !== 4'b0001) begin n_fail++; $display("FAIL rmid_sreq got %b exp 0001", s_req_o); end
        rst_n = 1'b0;
        #1;
        n_chk += 1;
        if (s_req_o !== 4'b0000) begin n_fail++; $display("FAIL rmid_async got %b exp 0000", s_req_o); end
        m_req_i = 1'b0;
        s_ready_i = 4'b0001;
        tick(); tick();
        n_chk += 1;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_noresp got %0b exp 0", m_ready_o); end
        s_ready_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_req_i = 1'b1; m_addr_i = 32'h1001_0204;
        tick();
        s_ready_i = 4'b0100;
        s_rdata_i[64 +: 32] = 32'h0000_005A;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_after_ready got %0b exp 1", m_ready_o); end
        if (m_rdata_o !== 32'h0000_005A) begin n_fail++; $display("FAIL rmid_after_rdata got %h exp 0000005a", m_rdata_o); end
        m_req_i = 1'b0; s_ready_i = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1001_0040;
        s_rdata_i[0 +: 32]  = 32'h1111_1111;
        s_rdata_i[32 +: 32] = 32'h2222_2222;
        tick();
        s_ready_i = 4'b0001;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ram_ready got %0b exp 1", m_ready_o); end
        if (m_rdata_o !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_ram_rdata got %h exp 11111111", m_rdata_o); end
        m_addr_i = 32'h0040_0008; s_ready_i = '0;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_ready got %0b exp 0", m_ready_o); end
        if (s_req_o !== 4'b0000) begin n_fail++; $display("FAIL b2b_gap_sreq got %b exp 0000", s_req_o); end
        tick();
        n_chk += 2;
        if (s_req_o !== 4'b0010) begin n_fail++; $display("FAIL b2b_rom_sreq got %b exp 0010", s_req_o); end
        if (s_addr_o !== 32'h0000_0008) begin n_fail++; $display("FAIL b2b_rom_saddr got %h exp 00000008", s_addr_o); end
        s_ready_i = 4'b0010;
        tick();
        n_chk += 2;
        if (m_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rom_ready got %0b exp 1", m_ready_o); end
        if (m_rdata_o !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rom_rdata got %h exp 22222222", m_rdata_o); end
        m_req_i = 1'b0; s_ready_i = '0;
        tick();
        n_chk += 1;
        if (m_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_pulse got %0b exp 0", m_ready_o); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_gpio_read();
        test_timeout();
        test_uart_write();
        test_miss();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
